// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter between N byte-stream
// requesters. Round-robin arbitration per message; a requester holds the
// grant until it sends a byte flagged last. Drives the transmitter handshake
// (data setup, one-cycle start strobe, wait for tdre to fall and rise).
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = 8,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int GW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N-1:0]    req_valid,
  input  logic [8*N-1:0]  req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ack,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  input  logic            tdre_i,
  output logic            busy,
  output logic [GW-1:0]   grant_id,
  output logic            locked,
  output logic            err_timeout
);

  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BW-1:0] BUSY_MAX = BW'(BUSY_TIMEOUT - 1);
  localparam logic [15:0]   LOCK_MAX = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FIRE, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_ack;
  logic [7:0]      r_data;
  logic            r_start;
  logic            r_busy;
  logic [GW-1:0]   r_grant;
  logic            r_locked;
  logic            r_err;
  logic [BW-1:0]   r_bcnt;
  logic [15:0]     r_lcnt;

  logic [N-1:0]    w_ack_nxt;
  logic [7:0]      w_data_nxt;
  logic [GW-1:0]   w_grant_nxt;
  logic            w_locked_nxt;
  logic            w_err_nxt;
  logic [BW-1:0]   w_bcnt_nxt;
  logic [15:0]     w_lcnt_nxt;

  logic            w_found;
  logic [GW-1:0]   w_win;
  int              w_dist;
  int              w_best;

  // Pick the winner: closest valid requester after the last grant, or the lock holder
  always_comb begin
    w_found = 1'b0;
    w_win   = r_grant;
    w_best  = N;
    w_dist  = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i - int'(r_grant) - 1 + 2 * N) % N;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_win   = GW'(i);
        w_found = 1'b1;
      end
    end
    if (r_locked) begin
      w_win   = r_grant;
      w_found = req_valid[r_grant];
    end
  end

  // Next-state and next-output decode for the handshake sequencer
  always_comb begin
    w_state_nxt  = r_state;
    w_ack_nxt    = '0;
    w_data_nxt   = r_data;
    w_grant_nxt  = r_grant;
    w_locked_nxt = r_locked;
    w_err_nxt    = 1'b0;
    w_bcnt_nxt   = r_bcnt;
    w_lcnt_nxt   = r_lcnt;
    case (r_state)
      S_IDLE: begin
        // An X on tdre_i fails the equality test, so nothing dispatches.
        if ((tdre_i == 1'b1) && w_found) begin
          w_state_nxt         = S_SETUP;
          w_grant_nxt         = w_win;
          w_data_nxt          = req_data[{w_win, 3'b000} +: 8];
          w_ack_nxt[w_win]    = 1'b1;
          w_locked_nxt        = ~req_last[w_win];
          w_lcnt_nxt          = '0;
        end else if (r_locked && !req_valid[r_grant]) begin
          if (r_lcnt == LOCK_MAX) begin
            w_locked_nxt = 1'b0;
            w_err_nxt    = 1'b1;
            w_lcnt_nxt   = '0;
          end else begin
            w_lcnt_nxt = r_lcnt + 16'd1;
          end
        end
      end
      S_SETUP: w_state_nxt = S_FIRE;
      S_FIRE: begin
        w_state_nxt = S_WAIT_BUSY;
        w_bcnt_nxt  = '0;
      end
      S_WAIT_BUSY: begin
        if (tdre_i == 1'b0) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_bcnt == BUSY_MAX) begin
          // Transmitter never took the byte; it is dropped and the lock freed.
          w_state_nxt  = S_IDLE;
          w_err_nxt    = 1'b1;
          w_locked_nxt = 1'b0;
        end else begin
          w_bcnt_nxt = r_bcnt + BW'(1);
        end
      end
      S_WAIT_DONE: if (tdre_i == 1'b1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Registered outputs and counters; strobes derive from the next state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ack    <= '0;
      r_data   <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_grant  <= GW'(N - 1);
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_bcnt   <= '0;
      r_lcnt   <= '0;
    end else begin
      r_ack    <= w_ack_nxt;
      r_data   <= w_data_nxt;
      r_start  <= (w_state_nxt == S_FIRE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_grant  <= w_grant_nxt;
      r_locked <= w_locked_nxt;
      r_err    <= w_err_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_lcnt   <= w_lcnt_nxt;
    end
  end

  assign req_ack     = r_ack;
  assign tx_data     = r_data;
  assign tx_start    = r_start;
  assign busy        = r_busy;
  assign grant_id    = r_grant;
  assign locked      = r_locked;
  assign err_timeout = r_err;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter between N byte-stream requesters.
- Round-robin arbitration per message; a requester keeps the grant until it sends a byte flagged last.
- Sequences the transmitter handshake: data setup, one-cycle start pulse, then waits for transmit-data-register-empty (tdre) to fall and rise again.
- Sits between client logic and the transmitter's tx_data/ready/tdre pins.

Parameters:
- N, 4: number of requesters (2..8); GW = clog2(N).
- BUSY_TIMEOUT, 8: cycles allowed in WAIT_BUSY for tdre_i to fall before aborting.
- LOCK_TIMEOUT, 65535: idle cycles a locked requester may stall before its lock is forcibly released (16-bit counter).

Ports:
- clk, in, 1: clock.
- clr, in, 1: reset, asynchronous, active-high.
- req_valid, in, N: requester i has a byte pending.
- req_data, in, 8*N: byte of requester i at [8i+7:8i].
- req_last, in, N: byte of requester i ends its message.
- req_ack, out, N: one-cycle pulse; byte of requester i accepted.
- tx_data, out, 8: byte to transmitter; registered.
- tx_start, out, 1: transmitter ready strobe; registered.
- tdre_i, in, 1: transmitter empty flag.
- busy, out, 1: high in any state except IDLE.
- grant_id, out, GW: index of the current/last granted requester.
- locked, out, 1: message lock held.
- err_timeout, out, 1: one-cycle pulse on BUSY or LOCK timeout.

Behaviour:
- Reset values: state=IDLE, req_ack=0, tx_data=0, tx_start=0, busy=0, grant_id=N-1, locked=0, err_timeout=0, counters=0.
- All outputs are registered.
- IDLE:
  - Dispatches only when tdre_i==1. While tdre_i is 0 or X after reset, no dispatch.
  - Unlocked: search req_valid from (grant_id+1) mod N upward with wrap; first set bit wins.
  - Locked: only requester grant_id is eligible.
  - On a winner g: grant_id<=g, tx_data<=req_data[g], req_ack[g]<=1 for one cycle, locked<=~req_last[g], state->SETUP.
- SETUP: 1 cycle, tx_start=0, tx_data held stable so the transmitter latches it; ->FIRE.
- FIRE: tx_start=1 for exactly 1 cycle; ->WAIT_BUSY with busy counter cleared.
- WAIT_BUSY:
  - tdre_i==0 -> WAIT_DONE.
  - Otherwise count up. At count==BUSY_TIMEOUT-1: err_timeout pulse, locked<=0, ->IDLE. The byte counts as acked and lost.
- WAIT_DONE: stay until tdre_i==1, then ->IDLE. No timeout (a frame takes ~10 bit times).
- tx_data is held constant from SETUP through WAIT_DONE.
- Lock stall: in IDLE with locked=1 and req_valid[grant_id]=0, the lock counter increments. At LOCK_TIMEOUT-1: locked<=0, err_timeout pulse, counter cleared. The counter clears on any dispatch.
- Other requesters' valid while locked: ignored; no ack.
- req_valid may drop without an ack. Requesters must hold data/last stable while valid and not acked.
- Simultaneous ack and new valid from the same requester: the next byte is considered only on the next IDLE visit.
- Minimum byte-to-byte spacing: IDLE+SETUP+FIRE+busy latency+frame; back-to-back acks are never closer than 4 cycles.
- clr mid-operation: immediate return to reset values. tx_start drops to 0 asynchronously and any in-flight frame is abandoned by the controller.
- N=1: round robin degenerates to a single requester; lock logic is unchanged.

Test Plan:
- Single byte: req_valid=0001, data0=0x55, last=1, tdre_i modelled by the real transmitter -> ack[0] pulse, tx_data=0x55 at SETUP, one tx_start pulse, serial line shows 0x55 LSB-first, busy returns 0, locked=0.
- Fairness: all four valid, last=1, after reset -> grant order 0,1,2,3,0. Each ack is one cycle, and there is no second ack before tdre_i rises.
- Message lock: req0 sends 0x48 (last=0), 0x49 (last=1) while req1 is valid with 0xAA -> order 0x48, 0x49, then 0xAA. locked is 1 between the first two bytes.
- Lock timeout: req0 sends last=0 then drops valid, req2 valid; LOCK_TIMEOUT=16 -> after 16 idle cycles err_timeout pulses, locked=0, req2 granted.
- Busy timeout: tdre_i tied 1, BUSY_TIMEOUT=8 -> after FIRE, 8 cycles later err_timeout pulse, IDLE, next requester served.
- Reset mid-frame: assert clr during WAIT_DONE -> all outputs reset values that cycle, grant_id=N-1. After release with req_valid=1000 -> requester 3 granted first.
